// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader and its instruction memory.
// Loader FSM states, default memory geometry and the length-byte encoding.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // A length byte equal to this value means "fill the whole memory".
  localparam int LEN_ZERO_MEANS_FULL = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_mem_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// The contents have no reset, so a program survives a loader reset.
module imem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Store the byte on the write edge; a same-cycle fetch still sees the old value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Program loader in front of an instruction memory. A length byte and N data
// bytes are streamed in, written from address 0, then the CPU is released.
// Optional feature: define PROG_CHECKSUM_EN to require a trailing checksum
// byte making the modulo-256 sum of length, data and checksum equal zero.
module prog_loader_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              run_start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  // The count needs one extra bit so that a full-memory load is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(2**ADDR_W);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  count_inc;
  logic              xfer;
  logic              we;
  logic              last_byte;

  assign xfer      = rx_valid & rx_ready;
  assign we        = (state == DATA) & xfer & ~load_start;
  assign count_inc = count + CNT_W'(1);
  assign last_byte = (count_inc == len);
  assign busy      = rx_ready;

`ifdef PROG_CHECKSUM_EN
  logic [7:0] checksum;
  logic [7:0] sum_next;
  assign sum_next = checksum + 8'(rx_data);
`endif

  // Next-state decision; a load request overrides everything else.
  always_comb begin
    next_state = state;
    if (load_start) begin
      next_state = LEN;
    end else begin
      case (state)
        IDLE: if (run_start) next_state = RUN;
        LEN:  if (xfer) next_state = DATA;
        DATA: begin
          if (xfer && last_byte) begin
`ifdef PROG_CHECKSUM_EN
            next_state = CHK;
`else
            next_state = RUN;
`endif
          end
        end
`ifdef PROG_CHECKSUM_EN
        CHK:  if (xfer) next_state = (sum_next == 8'h00) ? RUN : ERR;
`endif
        default: next_state = state;
      endcase
    end
  end

  // State register, outputs decoded from the next state, and the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      rx_ready  <= 1'b0;
      load_done <= 1'b0;
      addr      <= '0;
      count     <= '0;
      len       <= '0;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state != RUN);
      rx_ready  <= (next_state == LEN) || (next_state == DATA) || (next_state == CHK);
      load_done <= (next_state == RUN) && ((state == DATA) || (state == CHK));
      if ((state == LEN) && xfer && !load_start) begin
        addr  <= '0;
        count <= '0;
        len   <= (rx_data == DATA_W'(LEN_ZERO_MEANS_FULL)) ? FULL_LEN : CNT_W'(rx_data);
      end else if (we) begin
        addr  <= addr + ADDR_W'(1);
        count <= count_inc;
      end
    end
  end

`ifdef PROG_CHECKSUM_EN
  // Running sum over the length, data and checksum bytes, plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= 8'h00;
      load_err <= 1'b0;
    end else if (load_start) begin
      checksum <= 8'h00;
      load_err <= 1'b0;
    end else if (xfer) begin
      case (state)
        LEN:     checksum <= 8'(rx_data);
        DATA:    checksum <= sum_next;
        CHK: begin
          checksum <= sum_next;
          if (sum_next != 8'h00) load_err <= 1'b1;
        end
        default: checksum <= checksum;
      endcase
    end
  end
`else
  assign load_err = 1'b0;
`endif

  imem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_imem (
    .clk  (clk),
    .we   (we),
    .waddr(addr),
    .wdata(rx_data),
    .raddr(pc),
    .rdata(instr)
  );

endmodule

// File: tb/tb_prog_loader_mem.sv
// Testbench for prog_loader_mem: table-driven vectors plus directed sequences
// for full-memory loads, load collisions, mid-load reset and checksum errors.
// Honours PROG_CHECKSUM_EN the same way the design does.
module tb_prog_loader_mem;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       run_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] pc;
  logic [7:0] instr;
  logic       cpu_reset;
  logic       busy;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      name;
    logic       ls;
    logic       rs;
    logic       rv;
    logic [7:0] rxd;
    logic [7:0] pcv;
    logic       ecr;
    logic       erdy;
    logic       eld;
    logic       ci;
    logic [7:0] einstr;
  } vec_t;

  vec_t vecs[$];

  prog_loader_mem #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .run_start (run_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .pc        (pc),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(string name, logic ls, logic rs, logic rv,
                               logic [7:0] rxd, logic [7:0] pcv, logic ecr,
                               logic erdy, logic eld, logic ci, logic [7:0] einstr);
    vec_t v;
    v.name = name; v.ls = ls; v.rs = rs; v.rv = rv; v.rxd = rxd; v.pcv = pcv;
    v.ecr = ecr; v.erdy = erdy; v.eld = eld; v.ci = ci; v.einstr = einstr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One table row: drive for a cycle, then compare the post-edge outputs.
  task automatic applyStimulus(input vec_t v);
    load_start = v.ls;
    run_start  = v.rs;
    rx_valid   = v.rv;
    rx_data    = v.rxd;
    pc         = v.pcv;
    tick();
    checkOutput({v.name, ".cpu_reset"}, 8'(cpu_reset), 8'(v.ecr));
    checkOutput({v.name, ".rx_ready"},  8'(rx_ready),  8'(v.erdy));
    checkOutput({v.name, ".busy"},      8'(busy),      8'(v.erdy));
    checkOutput({v.name, ".load_done"}, 8'(load_done), 8'(v.eld));
    checkOutput({v.name, ".load_err"},  8'(load_err),  8'h00);
    if (v.ci) checkOutput({v.name, ".instr"}, instr, v.einstr);
  endtask

  task automatic doReset();
    reset = 1'b1; load_start = 1'b0; run_start = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulseLoad();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    int errs;
    pc = 8'h00;
    reset = 1'b1; load_start = 1'b0; run_start = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;

    // Reset values
    doReset();
    checkOutput("rst.cpu_reset", 8'(cpu_reset), 8'h01);
    checkOutput("rst.rx_ready",  8'(rx_ready),  8'h00);
    checkOutput("rst.busy",      8'(busy),      8'h00);
    checkOutput("rst.load_done", 8'(load_done), 8'h00);
    checkOutput("rst.load_err",  8'(load_err),  8'h00);

    // Full-memory load: length 00 then bytes 0..255
    pulseLoad();
    sendByte(8'h00);
    for (int i = 0; i < 256; i++) begin
      sendByte(8'(i));
      if (i == 254) begin
        checkOutput("full.busy_at_254", 8'(busy), 8'h01);
        checkOutput("full.cpu_reset_at_254", 8'(cpu_reset), 8'h01);
      end
    end
`ifdef PROG_CHECKSUM_EN
    checkOutput("full.in_chk", 8'(busy), 8'h01);
    sendByte(8'h80);
`endif
    checkOutput("full.cpu_reset", 8'(cpu_reset), 8'h00);
    checkOutput("full.load_done", 8'(load_done), 8'h01);
    checkOutput("full.rx_ready",  8'(rx_ready),  8'h00);
    checkOutput("full.addr_wrap", 8'(dut.addr),  8'h00);
    tick();
    checkOutput("full.done_once", 8'(load_done), 8'h00);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      pc = 8'(i);
      #1;
      if (instr !== 8'(i)) errs++;
    end
    checkOutput("full.mem_errs", 8'(errs), 8'h00);

    // Basic load, run-state behaviour and rx ignored in RUN
    doReset();
    vecs.push_back(mkv("idle",     0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mkv("ldstart",  1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mkv("len03",    0, 0, 1, 8'h03, 8'h00, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mkv("byteD5",   0, 0, 1, 8'hD5, 8'h00, 1, 1, 0, 1, 8'hD5));
    vecs.push_back(mkv("byte1F",   0, 0, 1, 8'h1F, 8'h01, 1, 1, 0, 1, 8'h1F));
`ifdef PROG_CHECKSUM_EN
    vecs.push_back(mkv("byteF0",   0, 0, 1, 8'hF0, 8'h01, 1, 1, 0, 1, 8'h1F));
    vecs.push_back(mkv("chk19",    0, 0, 1, 8'h19, 8'h01, 0, 0, 1, 1, 8'h1F));
`else
    vecs.push_back(mkv("byteF0",   0, 0, 1, 8'hF0, 8'h01, 0, 0, 1, 1, 8'h1F));
`endif
    vecs.push_back(mkv("run1",     0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 8'h1F));
    vecs.push_back(mkv("run_pc0",  0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hD5));
    vecs.push_back(mkv("run_pc2",  0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 1, 8'hF0));
    vecs.push_back(mkv("rxAA_a",   0, 0, 1, 8'hAA, 8'h03, 0, 0, 0, 1, 8'h03));
    vecs.push_back(mkv("rxAA_b",   0, 0, 1, 8'hAA, 8'h03, 0, 0, 0, 1, 8'h03));
    vecs.push_back(mkv("rxAA_pc0", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hD5));
    vecs.push_back(mkv("rs_inrun", 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hD5));
    foreach (vecs[i]) applyStimulus(vecs[i]);
    run_start = 1'b0;

    // Collision: load_start with a byte in DATA after 2 of 5 bytes
    pc = 8'h00;
    pulseLoad();
    checkOutput("coll.cpu_reset_up", 8'(cpu_reset), 8'h01);
    sendByte(8'h05);
    rx_valid = 1'b1; rx_data = 8'h11; pc = 8'h00;
    #1;
    checkOutput("coll.same_addr_old", instr, 8'hD5);
    tick();
    checkOutput("coll.same_addr_new", instr, 8'h11);
    sendByte(8'h22);
    load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    tick();
    load_start = 1'b0; rx_valid = 1'b0;
    checkOutput("coll.state_len", 8'(dut.state), 8'(LEN));
    checkOutput("coll.cpu_reset", 8'(cpu_reset), 8'h01);
    checkOutput("coll.rx_ready",  8'(rx_ready),  8'h01);
    pc = 8'h02;
    #1;
    checkOutput("coll.not_written", instr, 8'hF0);
    sendByte(8'h01);
    sendByte(8'h44);
`ifdef PROG_CHECKSUM_EN
    sendByte(8'hBB);
`endif
    checkOutput("coll.reload_done", 8'(load_done), 8'h01);
    checkOutput("coll.reload_run",  8'(cpu_reset), 8'h00);
    pc = 8'h00; #1;
    checkOutput("coll.mem0", instr, 8'h44);
    pc = 8'h01; #1;
    checkOutput("coll.mem1", instr, 8'h22);

    // Reset mid-DATA, then run_start without a load
    pulseLoad();
    sendByte(8'h04);
    sendByte(8'h55);
    sendByte(8'h66);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid.cpu_reset", 8'(cpu_reset), 8'h01);
    checkOutput("mid.rx_ready",  8'(rx_ready),  8'h00);
    checkOutput("mid.state",     8'(dut.state), 8'(IDLE));
    pc = 8'h00; #1;
    checkOutput("mid.mem0", instr, 8'h55);
    pc = 8'h01; #1;
    checkOutput("mid.mem1", instr, 8'h66);
    pc = 8'h02; #1;
    checkOutput("mid.mem2", instr, 8'hF0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    checkOutput("rs.cpu_reset", 8'(cpu_reset), 8'h00);
    checkOutput("rs.load_done", 8'(load_done), 8'h00);
    tick();
    checkOutput("rs.load_done2", 8'(load_done), 8'h00);
    pulseLoad();
    checkOutput("run_to_len.cpu_reset", 8'(cpu_reset), 8'h01);
    checkOutput("run_to_len.rx_ready",  8'(rx_ready),  8'h01);

`ifdef PROG_CHECKSUM_EN
    // Bad checksum leads to ERR; only load_start leaves it
    doReset();
    pulseLoad();
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h00);
    checkOutput("err.state",     8'(dut.state), 8'(ERR));
    checkOutput("err.load_err",  8'(load_err),  8'h01);
    checkOutput("err.cpu_reset", 8'(cpu_reset), 8'h01);
    checkOutput("err.rx_ready",  8'(rx_ready),  8'h00);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    checkOutput("err.rs_ignored", 8'(dut.state), 8'(ERR));
    checkOutput("err.sticky",     8'(load_err),  8'h01);
    pulseLoad();
    checkOutput("err.cleared",  8'(load_err),  8'h00);
    checkOutput("err.to_len",   8'(dut.state), 8'(LEN));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
